// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store initiator: access sizes and FSM states.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory pins of the load/store initiator.
interface mem_access_unit_if #(parameter int N = 32);

   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [1:0]   req_size;
   logic         req_signed;
   logic [N-1:0] req_addr;
   logic [N-1:0] req_wdata;

   logic         rsp_valid;
   logic         rsp_err;
   logic [N-1:0] rsp_rdata;

   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic         mem_we;
   logic [N-1:0] mem_rdata;

   // master is the initiator itself; slave is the execute stage plus memory
   modport master (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [1:0]   size,
   input  logic [1:0]   lane,
   input  logic         is_signed,
   input  logic [N-1:0] word,
   input  logic [N-1:0] wdata,
   output logic [N-1:0] load_data,
   output logic [N-1:0] store_data
);

   logic [N-1:0] shifted;

   always_comb begin
      shifted = word >> {lane, 3'b000};
      case (size)
         SZ_BYTE: load_data = is_signed ? {{(N-8){shifted[7]}}, shifted[7:0]}
                                        : {{(N-8){1'b0}}, shifted[7:0]};
         SZ_HALF: load_data = is_signed ? {{(N-16){shifted[15]}}, shifted[15:0]}
                                        : {{(N-16){1'b0}}, shifted[15:0]};
         default: load_data = word;
      endcase
   end

   // A word store bypasses the merge so the captured word is irrelevant
   always_comb begin
      store_data = word;
      case (size)
         SZ_BYTE: store_data[{lane, 3'b000} +: 8]        = wdata[7:0];
         SZ_HALF: store_data[{lane[1], 4'b0000} +: 16]  = wdata[15:0];
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-ported word-addressed memory with
// read-modify-write for sub-word stores and one-cycle response pulses.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int N     = 32,
   parameter int Depth = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_access_unit_if.master bus
);

   localparam int AW = $clog2(Depth);

   state_t         state;
   logic           we_q;
   logic           signed_q;
   logic           err_q;
   logic [1:0]     size_q;
   logic [1:0]     lane_q;
   logic [AW-1:0]  idx_q;
   logic [N-1:0]   wdata_q;
   logic [N-1:0]   word_q;

   logic           req_err;
   logic [N-1:0]   load_data;
   logic [N-1:0]   store_data;

   always_comb begin
      req_err = (bus.req_size == 2'b11)
             || (bus.req_size == SZ_HALF && bus.req_addr[0])
             || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
             || (bus.req_addr[N-1:AW+2] != '0);
   end

   // req_ready is high only in IDLE, so req_valid there is an accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= SZ_BYTE;
         lane_q   <= 2'b00;
         idx_q    <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q     <= bus.req_we;
                  signed_q <= bus.req_signed;
                  err_q    <= req_err;
                  size_q   <= bus.req_size;
                  lane_q   <= bus.req_addr[1:0];
                  idx_q    <= bus.req_addr[AW+1:2];
                  wdata_q  <= bus.req_wdata;
                  if (req_err)
                     state <= RESP;
                  else if (bus.req_we && bus.req_size == SZ_WORD)
                     state <= WRITE;
                  else
                     state <= READ;
               end
            end
            READ: begin
               word_q <= bus.mem_rdata;
               state  <= we_q ? WRITE : RESP;
            end
            WRITE:   state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   mem_lane_align #(.N(N)) u_align (
      .size       (size_q),
      .lane       (lane_q),
      .is_signed  (signed_q),
      .word       (word_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   // Outputs decode state so reset drops mem_we without waiting for an edge
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_err   = (state == RESP) && err_q;
   assign bus.rsp_rdata = (state == RESP && !err_q && !we_q) ? load_data : '0;
   assign bus.mem_addr  = {{(N-AW){1'b0}}, idx_q};
   assign bus.mem_we    = (state == WRITE);
   assign bus.mem_wdata = (state == WRITE) ? store_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 32-word memory model.
module tb_mem_access_unit;

   logic clk;
   logic rst_n;
   logic doPreload;

   logic [31:0] mem [0:31];

   int checkCount;
   int passCount;
   int accCount;

   int          obsLat;
   int          obsWeCount;
   int          obsReadyHigh;
   logic        obsErr;
   logic        obsPostValid;
   logic [31:0] obsRdata;
   logic [31:0] obsWeAddr;
   logic [31:0] obsWeData;

   mem_access_unit_if #(.N(32)) bus ();

   mem_access_unit #(.N(32), .Depth(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr[4:0]];

   always @(posedge clk) begin
      if (doPreload) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
         mem[0] <= 32'd1; mem[1] <= 32'd2; mem[2] <= 32'd3; mem[3] <= 32'd4;
         mem[4] <= 32'd5; mem[5] <= 32'd6; mem[7] <= 32'd7;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
      end
   end

   always @(posedge clk) begin
      if (rst_n && bus.req_valid && bus.req_ready) accCount <= accCount + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
   endtask

   // One request, then watch until the response pulse (bounded)
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
      int waitCycles;
      @(negedge clk);
      waitCycles = 0;
      while (!bus.req_ready && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      obsLat = 99; obsWeCount = 0; obsReadyHigh = 0;
      obsErr = 1'b0; obsRdata = '0; obsWeAddr = '0; obsWeData = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_we) begin
            obsWeCount++;
            obsWeAddr = bus.mem_addr;
            obsWeData = bus.mem_wdata;
         end
         if (bus.req_ready) obsReadyHigh++;
         if (bus.rsp_valid) begin
            obsLat   = c;
            obsErr   = bus.rsp_err;
            obsRdata = bus.rsp_rdata;
            break;
         end
      end
      @(negedge clk);
      obsPostValid = bus.rsp_valid;
   endtask

   task automatic expectTxn(input string tag, input int lat, input logic err,
                            input logic [31:0] rdata, input int weCount);
      checkOutput({tag, " latency"}, obsLat, lat);
      checkOutput({tag, " rsp_err"}, {31'd0, obsErr}, {31'd0, err});
      checkOutput({tag, " rsp_rdata"}, obsRdata, rdata);
      checkOutput({tag, " mem_we pulses"}, obsWeCount, weCount);
      checkOutput({tag, " ready low"}, obsReadyHigh, 0);
      checkOutput({tag, " single pulse"}, {31'd0, obsPostValid}, 32'd0);
   endtask

   initial begin
      int accBase;
      int lateValid;
      checkCount = 0; passCount = 0; accCount = 0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      rst_n = 1'b0;
      doPreload = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
      checkOutput("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
      checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
      checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);
      doPreload = 1'b0;
      rst_n = 1'b1;

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
      expectTxn("lw 0x04", 2, 1'b0, 32'h0000_0002, 0);

      // Back-to-back with req_valid held high
      @(negedge clk);
      accBase = accCount;
      bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
      bus.req_addr = 32'h00; bus.req_valid = 1'b1;
      @(negedge clk);
      checkOutput("b2b ready after accept", {31'd0, bus.req_ready}, 32'd0);
      bus.req_addr = 32'h0C;
      @(negedge clk);
      checkOutput("b2b ready in resp", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("b2b first rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("b2b first rdata", bus.rsp_rdata, 32'h0000_0001);
      @(negedge clk);
      checkOutput("b2b ready after resp", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("b2b no dup accept", accCount - accBase, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("b2b second rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("b2b second rdata", bus.rsp_rdata, 32'h0000_0004);
      repeat (3) @(negedge clk);
      checkOutput("b2b accept count", accCount - accBase, 2);

      applyStimulus(1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFF_FFAB);
      expectTxn("sb 0x09", 3, 1'b0, 32'h0, 1);
      checkOutput("sb 0x09 mem_addr", obsWeAddr, 32'd2);
      checkOutput("sb 0x09 mem_wdata", obsWeData, 32'h0000_AB03);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
      expectTxn("lb 0x09", 2, 1'b0, 32'hFFFF_FFAB, 0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
      expectTxn("lbu 0x09", 2, 1'b0, 32'h0000_00AB, 0);

      applyStimulus(1'b1, 2'b01, 1'b0, 32'h1E, 32'h1234_BEEF);
      expectTxn("sh 0x1E", 3, 1'b0, 32'h0, 1);
      checkOutput("sh 0x1E mem_addr", obsWeAddr, 32'd7);
      checkOutput("sh 0x1E mem_wdata", obsWeData, 32'hBEEF_0007);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h1E, 32'h0);
      expectTxn("lh 0x1E", 2, 1'b0, 32'hFFFF_BEEF, 0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h1E, 32'h0);
      expectTxn("lhu 0x1E", 2, 1'b0, 32'h0000_BEEF, 0);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);
      expectTxn("sw 0x14", 2, 1'b0, 32'h0, 1);
      checkOutput("sw 0x14 mem_addr", obsWeAddr, 32'd5);
      checkOutput("sw 0x14 mem_wdata", obsWeData, 32'hCAFE_F00D);
      applyStimulus(1'b0, 2'b10, 1'b1, 32'h14, 32'h0);
      expectTxn("lw 0x14", 2, 1'b0, 32'hCAFE_F00D, 0);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
      expectTxn("lbu 0x17", 2, 1'b0, 32'h0000_00CA, 0);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
      expectTxn("lb 0x17", 2, 1'b0, 32'hFFFF_FFCA, 0);

      applyStimulus(1'b0, 2'b01, 1'b1, 32'h03, 32'h0);
      expectTxn("lh misaligned", 1, 1'b1, 32'h0, 0);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
      expectTxn("size 11", 1, 1'b1, 32'h0, 0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF);
      expectTxn("sw out of range", 1, 1'b1, 32'h0, 0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
      expectTxn("lw 0x00 untouched", 2, 1'b0, 32'h0000_0001, 0);

      // Reset during the WRITE cycle of a word store
      @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
      bus.req_addr = 32'h10; bus.req_wdata = 32'h1234_5678; bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst mem_we in write", {31'd0, bus.mem_we}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst mem_we async drop", {31'd0, bus.mem_we}, 32'd0);
      checkOutput("rst req_ready async", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lateValid = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) lateValid++;
      end
      checkOutput("rst no response", lateValid, 0);
      checkOutput("rst req_ready after release", {31'd0, bus.req_ready}, 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
